// File: rtl/bus_ram.sv
// Data RAM device on the system bus: self-clears after reset, then serves one load or store per cycle.
// Optional per-word even parity with a sticky read error flag when BUS_RAM_PARITY_EN is defined.
module bus_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4,
  parameter logic [1:0]  DEV_ID = 2'b01
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        dev,
  input  logic [ADDR_W-1:0] opaddr,
  input  logic              ldstr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  output logic              ready,
  input  logic              parity_inject,
  output logic              parity_err
);

  localparam int unsigned       DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic accept_c;
  logic load_c;
  logic store_c;

  // A request is taken only once the device is ready and the select matches.
  assign accept_c = ready && (dev == DEV_ID);
  assign load_c   = accept_c && !ldstr;
  assign store_c  = accept_c && ldstr;

  // Memory write port: the clear sweep owns it until RUN, then accepted stores do.
  always_ff @(posedge clock) begin
    if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else if (store_c) begin
      mem[opaddr] <= data_in;
    end
  end

  // Control FSM with registered ready and load-data outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= CLEAR;
      cnt      <= '0;
      ready    <= 1'b0;
      data_out <= '0;
      data_oe  <= 1'b0;
    end else begin
      data_oe <= 1'b0;
      case (state)
        CLEAR: begin
          cnt <= cnt + ADDR_W'(1);
          if (cnt == LAST) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          if (load_c) begin
            data_out <= mem[opaddr];
            data_oe  <= 1'b1;
          end
        end
        default: begin
          state <= CLEAR;
          ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef BUS_RAM_PARITY_EN
  logic mem_par [DEPTH];

  // Parity shadow array; inject flips the stored bit to model a corrupted word.
  always_ff @(posedge clock) begin
    if (state == CLEAR) begin
      mem_par[cnt] <= 1'b0;
    end else if (store_c) begin
      mem_par[opaddr] <= (^data_in) ^ parity_inject;
    end
  end

  // Sticky error: set on any accepted load whose stored parity disagrees with its data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      parity_err <= 1'b0;
    end else if (load_c && (mem_par[opaddr] != (^mem[opaddr]))) begin
      parity_err <= 1'b1;
    end
  end
`else
  logic unused_parity_inject;

  assign unused_parity_inject = parity_inject;
  assign parity_err           = 1'b0;
`endif

endmodule

// File: tb/tb_bus_ram.sv
// Randomized self-checking bench for bus_ram against a word-array reference model.
// Honours BUS_RAM_PARITY_EN when the same macro is defined for the build.
module tb_bus_ram;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 16;
  localparam logic [1:0]  DEV_ID = 2'b01;
  localparam logic [1:0]  IDLE   = 2'b00;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [1:0]        dev = IDLE;
  logic [ADDR_W-1:0] opaddr = '0;
  logic              ldstr = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic [DATA_W-1:0] data_out;
  logic              data_oe;
  logic              ready;
  logic              parity_inject = 1'b0;
  logic              parity_err;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: word contents, a per-word "stored corrupted" flag, and expected outputs.
  logic [DATA_W-1:0] m_mem [DEPTH];
  logic              m_bad [DEPTH];
  logic              m_ready = 1'b0;
  logic [DATA_W-1:0] exp_out = '0;
  logic              exp_oe  = 1'b0;
  logic              exp_err = 1'b0;

  bus_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEV_ID(DEV_ID)) dut (
    .clock         (clock),
    .reset         (reset),
    .dev           (dev),
    .opaddr        (opaddr),
    .ldstr         (ldstr),
    .data_in       (data_in),
    .data_out      (data_out),
    .data_oe       (data_oe),
    .ready         (ready),
    .parity_inject (parity_inject),
    .parity_err    (parity_err)
  );

  always #5 clock = ~clock;

  function automatic logic parity_on();
`ifdef BUS_RAM_PARITY_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < int'(DEPTH); i++) begin
      m_mem[i] = '0;
      m_bad[i] = 1'b0;
    end
    exp_out = '0;
    exp_oe  = 1'b0;
    exp_err = 1'b0;
  endfunction

  // Present one request for one edge, then advance the model by the spec rules.
  task automatic do_req(input logic [1:0] d, input int a, input logic st,
                        input logic [DATA_W-1:0] wd, input logic inj);
    dev           = d;
    opaddr        = ADDR_W'(a);
    ldstr         = st;
    data_in       = wd;
    parity_inject = inj;
    @(posedge clock);
    #1;
    exp_oe = 1'b0;
    if (m_ready && d == DEV_ID) begin
      if (st) begin
        m_mem[a] = wd;
        m_bad[a] = inj;
      end else begin
        exp_out = m_mem[a];
        exp_oe  = 1'b1;
        if (parity_on() && m_bad[a]) exp_err = 1'b1;
      end
    end
    dev           = IDLE;
    parity_inject = 1'b0;
  endtask

  task automatic idle_cycle();
    dev = IDLE;
    @(posedge clock);
    #1;
    exp_oe = 1'b0;
  endtask

  // Release reset and confirm ready stays low for exactly DEPTH edges.
  task automatic release_and_clear(input string tag);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 1; k <= int'(DEPTH); k++) begin
      @(posedge clock);
      #1;
      n_cmp++;
      if (ready !== (k == int'(DEPTH))) begin
        n_fail++;
        $display("FAIL %s ready at cycle %0d: got %b expected %b", tag, k, ready, (k == int'(DEPTH)));
      end
    end
    m_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    m_ready = 1'b0;
    model_clear();
    #2;
    n_cmp++;
    if (data_out !== '0 || data_oe !== 1'b0 || ready !== 1'b0 || parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: out=%h oe=%b rdy=%b perr=%b expected all zero",
               data_out, data_oe, ready, parity_err);
    end
    repeat (2) @(posedge clock);
    // Requests during CLEAR must be dropped; drive one while clearing.
    dev = DEV_ID; ldstr = 1'b1; opaddr = ADDR_W'(2); data_in = 16'h5555;
    release_and_clear("reset_clear");
    dev = IDLE;
  endtask

  task automatic test_clear_contents();
    for (int a = 0; a < int'(DEPTH); a++) begin
      do_req(DEV_ID, a, 1'b0, '0, 1'b0);
      n_cmp++;
      if (data_oe !== 1'b1 || data_out !== 16'h0000) begin
        n_fail++;
        $display("FAIL clear_read addr %0d: oe=%b data=%h expected oe=1 data=0000", a, data_oe, data_out);
      end
    end
    idle_cycle();
    n_cmp++;
    if (data_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_read_oe_drop: oe=%b expected 0", data_oe);
    end
  endtask

  task automatic test_store_load();
    do_req(DEV_ID, 3, 1'b1, 16'hBEEF, 1'b0);
    n_cmp++;
    if (data_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL store_oe: oe=%b expected 0", data_oe);
    end
    do_req(DEV_ID, 3, 1'b0, '0, 1'b0);
    n_cmp++;
    if (data_oe !== 1'b1 || data_out !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL store_load: oe=%b data=%h expected oe=1 data=beef", data_oe, data_out);
    end
    idle_cycle();
    n_cmp++;
    if (data_oe !== 1'b0 || data_out !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL store_load_hold: oe=%b data=%h expected oe=0 data=beef", data_oe, data_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] vals [3];
    vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
    for (int i = 0; i < 3; i++) do_req(DEV_ID, i + 1, 1'b1, vals[i], 1'b0);
    for (int i = 0; i < 3; i++) begin
      do_req(DEV_ID, i + 1, 1'b0, '0, 1'b0);
      n_cmp++;
      if (data_oe !== 1'b1 || data_out !== vals[i]) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: oe=%b data=%h expected oe=1 data=%h", i, data_oe, data_out, vals[i]);
      end
    end
    idle_cycle();
    n_cmp++;
    if (data_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back_end: oe=%b expected 0", data_oe);
    end
  endtask

  task automatic test_dev_select();
    do_req(2'b10, 5, 1'b1, 16'h1234, 1'b0);
    do_req(2'b10, 5, 1'b0, '0, 1'b0);
    n_cmp++;
    if (data_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL dev_unselected_oe: oe=%b expected 0", data_oe);
    end
    do_req(DEV_ID, 5, 1'b0, '0, 1'b0);
    n_cmp++;
    if (data_oe !== 1'b1 || data_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL dev_select_read: oe=%b data=%h expected oe=1 data=0000", data_oe, data_out);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      logic [1:0] d;
      d = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : DEV_ID;
      do_req(d, int'($urandom_range(0, DEPTH - 1)), 1'($urandom_range(0, 1)),
             DATA_W'($urandom), 1'b0);
      n_cmp++;
      if (data_oe !== exp_oe || data_out !== exp_out || ready !== 1'b1 || parity_err !== exp_err) begin
        n_fail++;
        $display("FAIL random[%0d]: oe=%b data=%h rdy=%b perr=%b expected oe=%b data=%h rdy=1 perr=%b",
                 n, data_oe, data_out, ready, parity_err, exp_oe, exp_out, exp_err);
      end
    end
  endtask

  task automatic test_parity();
    do_req(DEV_ID, 7, 1'b1, 16'h00FF, 1'b1);
    n_cmp++;
    if (parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_store_only: perr=%b expected 0", parity_err);
    end
    do_req(DEV_ID, 7, 1'b0, '0, 1'b0);
    n_cmp++;
    if (parity_err !== parity_on() || data_out !== 16'h00FF) begin
      n_fail++;
      $display("FAIL parity_detect: perr=%b data=%h expected perr=%b data=00ff",
               parity_err, data_out, parity_on());
    end
    do_req(DEV_ID, 8, 1'b1, 16'h0F0E, 1'b0);
    do_req(DEV_ID, 8, 1'b0, '0, 1'b0);
    idle_cycle();
    n_cmp++;
    if (parity_err !== exp_err || exp_err !== parity_on()) begin
      n_fail++;
      $display("FAIL parity_sticky: perr=%b expected %b", parity_err, parity_on());
    end
  endtask

  task automatic test_reset_mid();
    do_req(DEV_ID, 9, 1'b1, 16'h4321, 1'b0);
    do_req(DEV_ID, 9, 1'b0, '0, 1'b0);
    // Load pending (oe high); now drive a store and hit reset before its edge.
    dev = DEV_ID; ldstr = 1'b1; opaddr = ADDR_W'(9); data_in = 16'hAAAA;
    #1;
    reset = 1'b1;
    m_ready = 1'b0;
    model_clear();
    #1;
    n_cmp++;
    if (data_out !== '0 || data_oe !== 1'b0 || ready !== 1'b0 || parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_values: out=%h oe=%b rdy=%b perr=%b expected all zero",
               data_out, data_oe, ready, parity_err);
    end
    @(posedge clock);
    dev = IDLE;
    release_and_clear("reset_mid_clear");
    do_req(DEV_ID, 9, 1'b0, '0, 1'b0);
    n_cmp++;
    if (data_oe !== 1'b1 || data_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_mid_store_lost: oe=%b data=%h expected oe=1 data=0000", data_oe, data_out);
    end
    do_req(DEV_ID, 3, 1'b0, '0, 1'b0);
    n_cmp++;
    if (data_out !== 16'h0000 || parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_recleared: data=%h perr=%b expected data=0000 perr=0", data_out, parity_err);
    end
  endtask

  initial begin
    test_reset();
    test_clear_contents();
    test_store_load();
    test_back_to_back();
    test_dev_select();
    test_random();
    test_parity();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_ram.md
# bus_ram

Data RAM device on the system bus, serving the sequencer's load and store states. It decodes the control-bus device select, captures the operation address and load/store strobe, and writes or returns one word per request. The sequencer drives its control outputs combinationally from state. This block registers every request and presents read data on the cycle after acceptance, for the sequencer to latch into MDR. After reset it self-clears its contents and holds `ready` low until clearing finishes.

## Interface
- `DATA_W`, default 16: word width; matches `sysbus.data`.
- `ADDR_W`, default 4: address width; depth is 2^ADDR_W; matches `ctlbus.opaddr`.
- `DEV_ID`, default 2'b01: `ctlbus.dev` code that selects this device.

Ports:
- `clock` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `dev` in 2: device select from `ctlbus.dev`.
- `opaddr` in ADDR_W: word address from `ctlbus.opaddr`.
- `ldstr` in 1: 0 = load, 1 = store.
- `data_in` in DATA_W: store data from the system bus.
- `data_out` out DATA_W: load data; the top level drives it onto `sysbus.data` when `data_oe` = 1.
- `data_oe` out 1: high while `data_out` holds valid load data.
- `ready` out 1: device is accepting requests.
- `parity_inject` in 1: test input; corrupts the stored parity of the word being written.
- `parity_err` out 1: sticky read-parity error flag.

## Operation
- FSM states: CLEAR, RUN.
  - `reset` high forces CLEAR and sets the clear counter to 0. The reset action is immediate (asynchronous).
  - CLEAR: each cycle writes 0 to `mem[cnt]` and increments `cnt`. When `cnt` reaches 2^ADDR_W-1, that word is written and the FSM moves to RUN.
  - RUN: steady state; no exit except `reset`.
- Reset values: `data_out`=0, `data_oe`=0, `ready`=0, `parity_err`=0, `cnt`=0. Memory contents are undefined until CLEAR completes.
- `ready` is 1 exactly when state = RUN.
- Accept condition: a request is accepted on an edge where `ready`=1 and `dev`==`DEV_ID`. Inputs with any other `dev` value are ignored.
- Store, accepted with `ldstr`=1: `mem[opaddr]` <= `data_in` at that edge. `data_oe` is 0 on the following cycle.
- Load, accepted with `ldstr`=0:
  - At that edge, `data_out` <= `mem[opaddr]` and `data_oe` <= 1.
  - With no load accepted on an edge, `data_oe` <= 0 and `data_out` holds its last value.
- Requests before `ready` (during CLEAR) are dropped silently; there is no queueing.
- Back-to-back loads: a new load can be accepted every cycle, and `data_oe` stays high.
- Store then load to the same address on the next edge returns the newly written word.
- Address is ADDR_W bits with no wrap logic; every address is valid.

## Timing
- Load latency: 1 cycle. Request at edge N; data valid from after edge N to edge N+1.
- Store: completes at the accepting edge. A load in the next cycle sees the new value.
- Clear time: 2^ADDR_W cycles after `reset` deasserts, so `ready` rises 16 cycles after reset release at default.
- Reset mid-operation: a pending load's `data_oe` drops immediately and the in-flight store is lost. The clear sequence then restarts from address 0.

## Configuration
- `BUS_RAM_PARITY_EN` defined:
  - Each word stores an extra even-parity bit computed from `data_in`. The bit is inverted when `parity_inject`=1 at the store edge.
  - CLEAR writes parity 0 alongside the zero data.
  - On each accepted load, a mismatch between stored parity and recomputed parity sets `parity_err` at the same edge that updates `data_out`.
  - `parity_err` stays 1 until `reset`.
- `BUS_RAM_PARITY_EN` not defined: no parity storage, `parity_inject` is ignored, and `parity_err` is constant 0.

## Test plan
- Reset release -> `ready`=0 for exactly 16 cycles, then 1. A load of every address 0..15 returns 0x0000 with `data_oe`=1 one cycle after each request.
- Store 0xBEEF to address 3, then load address 3 on the next edge -> `data_out`=0xBEEF, `data_oe`=1 in the following cycle.
- Back-to-back loads of addresses 1, 2, 3 holding 0x1111, 0x2222, 0x3333 -> `data_oe` high for 3 consecutive cycles with values in order, then low.
- Store 0x1234 to address 5 with `dev`=2'b10, then load address 5 with `dev`=`DEV_ID` -> returns 0x0000; `data_oe` stays 0 for the non-selected request.
- Assert `reset` while a load is pending and during a store of 0xAAAA -> outputs go to reset values immediately. After 16 clear cycles, that address reads 0x0000.
- With `BUS_RAM_PARITY_EN`: store 0x00FF to address 7 with `parity_inject`=1, then load address 7 -> `parity_err`=1 and stays 1 through later clean loads. Without the macro, the same stimulus gives `parity_err`=0.
